// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receiver and transmitter.
//   uart_state_e  - frame-level state encoding used by both directions
//   clks_per_bit  - rounded clock-to-baud divisor
//   CLK_HZ_DEF / BAUD_DEF - board defaults (12 MHz HFOSC, 115200 baud)
package uart_pkg;

    localparam int CLK_HZ_DEF = 12000000;
    localparam int BAUD_DEF   = 115200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    // Divisor rounded to the nearest integer so the bit-time error stays small.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset (flops load RST_VAL)
//   d_i    - asynchronous input bus
//   q_o    - synchronised output, two clk cycles behind d_i
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready output handshake.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
// Ports:
//   clk          - system clock (CLK_HZ)
//   rst_n        - asynchronous active-low reset
//   rx_i         - asynchronous serial line, idle high
//   data_o       - received word, LSB first on the line
//   valid_o      - data_o holds an unconsumed word
//   ready_i      - consumer takes data_o when valid_o && ready_i
//   frame_err_o  - one-cycle pulse, stop bit sampled low
//   overrun_o    - one-cycle pulse, word completed while previous unconsumed
//   parity_err_o - (UART_RX_PARITY_EN only) one-cycle pulse on parity mismatch
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEF,
    parameter int BAUD      = BAUD_DEF,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
    localparam logic [BW-1:0] IDX_LAST     = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic bit_end_s, half_end_s;
    logic cnt_clr_s, sample_bit_s, stop_sample_s, commit_s, ferr_s;

`ifdef UART_RX_PARITY_EN
    logic par_sample_s;
    logic par_bad_q;
    logic parity_err_q;
`endif

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    assign bit_end_s  = (cnt_q == CNT_BIT_END);
    assign half_end_s = (cnt_q == CNT_HALF_END);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) state_d = START;
                else       state_d = IDLE;
            end
            START: begin
                // Mid-start resample: a high line here means a glitch.
                if (half_end_s) state_d = rx_s ? IDLE : DATA;
                else            state_d = START;
            end
            DATA: begin
                if (bit_end_s && (bit_idx_q == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) state_d = STOP;
                else           state_d = PARITY;
            end
            STOP: begin
                if (bit_end_s) state_d = rx_s ? IDLE : BREAK;
                else           state_d = STOP;
            end
            BREAK: begin
                // A held-low line is reported once, then ignored until idle.
                if (rx_s) state_d = IDLE;
                else      state_d = BREAK;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output decode: counter control and sample strobes.
    always_comb begin
        cnt_clr_s     = (state_q == IDLE) || (state_d != state_q) ||
                        ((state_q == DATA) && bit_end_s);
        sample_bit_s  = (state_q == DATA) && bit_end_s;
        stop_sample_s = (state_q == STOP) && bit_end_s;
        ferr_s        = stop_sample_s && !rx_s;
`ifdef UART_RX_PARITY_EN
        par_sample_s  = (state_q == PARITY) && bit_end_s;
        commit_s      = stop_sample_s && rx_s && !par_bad_q;
`else
        commit_s      = stop_sample_s && rx_s;
`endif
    end

    // Bit-time counter, shift register and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= {CW{1'b0}};
            bit_idx_q <= {BW{1'b0}};
            shift_q   <= {DATA_BITS{1'b0}};
        end else begin
            cnt_q <= cnt_clr_s ? {CW{1'b0}} : (cnt_q + CW'(1));
            if (state_q == START) begin
                bit_idx_q <= {BW{1'b0}};
            end else if (sample_bit_s) begin
                bit_idx_q <= bit_idx_q + BW'(1);
            end
            if (sample_bit_s) begin
                shift_q[bit_idx_q] <= rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity check; a mismatch pulses the error and blocks the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= par_sample_s && ((^shift_q) ^ rx_s);
            if (state_q == START) begin
                par_bad_q <= 1'b0;
            end else if (par_sample_s) begin
                par_bad_q <= (^shift_q) ^ rx_s;
            end
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    // Output holding register, handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= {DATA_BITS{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= ferr_s;
            overrun_q   <= commit_s && valid_q && !ready_i;
            if (commit_s && (!valid_q || ready_i)) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at the default 12 MHz / 115200.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;

    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 115200;
    localparam int DB     = 8;
    localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int LAT = 2 + HALF + (DB + 1 + NPAR) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_i = 1'b1;
    logic          ready_i = 1'b1;
    logic [DB-1:0] data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          overrun_o;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_o;
    logic          bad_par = 1'b0;
`endif

    uart_rx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .DATA_BITS (DB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor state, sampled on the falling edge.
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    logic [DB-1:0] got_q[$];
    logic [DB-1:0] exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (valid_o) valid_cycles++;
            if (valid_o && !prev_valid) rise_cyc = cyc;
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err_o) perr_cnt++;
`endif
        end
        prev_valid = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cycles = 0;
        ferr_cnt = 0;
        ovr_cnt = 0;
        perr_cnt = 0;
        rise_cyc = -1;
        got_q.delete();
        exp_q.delete();
    endtask

    // Compare accepted words against the expected list, then empty both.
    task automatic check_rx(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check(tag, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_sym(input logic v, input int n);
        rx_i = v;
        idle(n);
    endtask

    // One full frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
        drive_sym(1'b0, CPB);
        for (int i = 0; i < DB; i++) drive_sym(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_sym(bad_par ? ~(^d) : (^d), CPB);
`endif
        drive_sym(stop_b, CPB);
    endtask

    initial begin
        int start_cyc;
        logic [DB-1:0] r;

        // Reset state.
        idle(5);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
        check("rst_ovr", {31'd0, overrun_o}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Single word with consumer ready: one-cycle valid, fixed latency.
        clear_mon();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        idle(20);
        exp_q.push_back(8'hA5);
        check_rx("a5_data");
        check("a5_valid_cycles", valid_cycles, 32'd1);
        check("a5_latency", rise_cyc - start_cyc, LAT);
        check("a5_ferr", ferr_cnt, 32'd0);
        check("a5_ovr", ovr_cnt, 32'd0);

        // Back-to-back words with consumer stalled: second word dropped.
        clear_mon();
        ready_i = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(20);
        check("ovr_valid_held", {31'd0, valid_o}, 32'd1);
        check("ovr_data_held", {24'd0, data_o}, 32'h3C);
        check("ovr_pulses", ovr_cnt, 32'd1);
        ready_i = 1'b1;
        idle(3);
        exp_q.push_back(8'h3C);
        check_rx("ovr_drain");
        check("ovr_valid_drop", {31'd0, valid_o}, 32'd0);

        // Low stop bit followed by a long break: one error, then recovery.
        clear_mon();
        send_frame(8'h55, 1'b0);
        drive_sym(1'b0, 3 * CPB);
        drive_sym(1'b1, 30);
        check("brk_ferr", ferr_cnt, 32'd1);
        check("brk_valid", valid_cycles, 32'd0);
        send_frame(8'h81, 1'b1);
        idle(20);
        exp_q.push_back(8'h81);
        check_rx("brk_next");
        check("brk_ferr_after", ferr_cnt, 32'd1);

        // Short glitch is ignored.
        clear_mon();
        drive_sym(1'b0, 20);
        drive_sym(1'b1, 200);
        check("gl_valid", valid_cycles, 32'd0);
        check("gl_ferr", ferr_cnt, 32'd0);
        send_frame(8'h00, 1'b1);
        idle(20);
        exp_q.push_back(8'h00);
        check_rx("gl_next");

        // Reset in the middle of a frame while a word is held.
        clear_mon();
        ready_i = 1'b0;
        r = 8'($urandom_range(1, 255));
        send_frame(r, 1'b1);
        idle(10);
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        check("hold_data", {24'd0, data_o}, {24'd0, r});
        drive_sym(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_sym(1'b0, CPB);
        drive_sym(1'b1, HALF);
        rst_n = 1'b0;
        idle(1);
        check("mrst_data", {24'd0, data_o}, 32'd0);
        check("mrst_valid", {31'd0, valid_o}, 32'd0);
        check("mrst_ferr", {31'd0, frame_err_o}, 32'd0);
        check("mrst_ovr", {31'd0, overrun_o}, 32'd0);
        idle(9);
        rst_n = 1'b1;
        clear_mon();
        ready_i = 1'b1;
        idle(20);
        send_frame(8'h12, 1'b1);
        idle(20);
        exp_q.push_back(8'h12);
        check_rx("mrst_next");
        check("mrst_valid_cycles", valid_cycles, 32'd1);
        check("mrst_ferr_cnt", ferr_cnt, 32'd0);
        check("mrst_ovr_cnt", ovr_cnt, 32'd0);

        // Random words with random idle gaps.
        clear_mon();
        for (int k = 0; k < 6; k++) begin
            r = 8'($urandom);
            exp_q.push_back(r);
            send_frame(r, 1'b1);
            idle($urandom_range(0, 40));
        end
        idle(20);
        check_rx("rand");
        check("rand_ferr", ferr_cnt, 32'd0);
        check("rand_ovr", ovr_cnt, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Parity good then parity bad.
        clear_mon();
        bad_par = 1'b0;
        send_frame(8'h07, 1'b1);
        idle(20);
        exp_q.push_back(8'h07);
        check_rx("par_ok");
        check("par_ok_err", perr_cnt, 32'd0);
        clear_mon();
        bad_par = 1'b1;
        send_frame(8'h07, 1'b1);
        idle(20);
        bad_par = 1'b0;
        check("par_bad_err", perr_cnt, 32'd1);
        check("par_bad_valid", valid_cycles, 32'd0);
        check("par_bad_ferr", ferr_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver for the UpDuino (iCE40 UP5K) platform, clocked from the on-chip HF oscillator divided to 12 MHz.
- Deserialises an asynchronous 8N1 line (default 115200 baud) from the FTDI bridge into bytes.
- Presents each byte on a valid/ready handshake to downstream logic in the top level.
- Serves as the receive end of the board's serial link; a matching transmitter exists in the same design.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- DATA_BITS, 8, payload bits per frame (5..8).

Ports:
- clk  input  1  system clock (12 MHz HFOSC output).
- rst_n  input  1  reset, asynchronous assert, active-low.
- rx_i  input  1  asynchronous serial line, idle high.
- data_o  output  DATA_BITS  received byte, LSB = first bit on the line.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: byte completed while the previous byte was still unconsumed.

Behaviour:
- Derived constants:
  - CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD; 104 at the defaults.
  - HALF_BIT = CLKS_PER_BIT / 2; 52 at the defaults.
  - Counter width = $clog2(CLKS_PER_BIT).
- Reset values: data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0; synchroniser flops = 1; FSM = IDLE.
- rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
- FSM states and transitions:
  - IDLE: on rx_s = 0, clear the counter and go to START.
  - START: after HALF_BIT cycles, resample. If rx_s = 1, it was a glitch; return to IDLE. Otherwise go to DATA with the counter and bit index cleared.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift-register position bit_idx (LSB first). After DATA_BITS samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - Sampled 1: commit the byte and go to IDLE.
    - Sampled 0: pulse frame_err_o, discard the byte, and go to BREAK.
  - BREAK: wait until rx_s = 1, then go to IDLE. This rejects long breaks as a single error.
- Commit is registered. The cycle after the stop sample, data_o and valid_o update.
- Latency from the start edge on rx_i to valid_o = 2 (sync) + HALF_BIT + (DATA_BITS+1)·CLKS_PER_BIT + 1 cycles. At the defaults this is 2+52+936+1 = 991.
- Handshake:
  - valid_o stays high and data_o stays stable until the cycle where valid_o && ready_i.
  - valid_o falls the cycle after acceptance unless a commit happens in the same cycle.
- Simultaneous events:
  - Commit with valid_o = 0: load data_o and set valid_o.
  - Commit with valid_o = 1 and ready_i = 1: load the new byte; valid_o stays 1; no overrun.
  - Commit with valid_o = 1 and ready_i = 0: keep the old byte, drop the new one, and pulse overrun_o.
- Reset mid-frame: all state returns to reset values immediately, and the partial byte is lost. After reset deasserts, a line already low waits in IDLE→START. If the line is low for more than half a bit, the byte is mis-framed; this is acceptable, and the stop check catches it.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and sampled at bit centre.
  - Parity is even, over the DATA_BITS bits.
  - Adds an output parity_err_o (1 bit, reset 0) that pulses for one cycle on mismatch. The byte is then discarded; stop-bit handling is unchanged.
  - Latency grows by CLKS_PER_BIT.
- Undefined: there is no PARITY state, no parity_err_o port, and the frame is 8N1.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK), shared with the transmitter's states.
  - Function clks_per_bit(clk_hz, baud) returning the rounded divisor.
  - Default constants CLK_HZ_DEF = 12000000 and BAUD_DEF = 115200.
- Sub-module sync_2ff (parameterised width, reset value 1). It is reused by other top-level inputs.

Test Plan:
- Send 0xA5 at 115200 with ready_i = 1 → valid_o high for exactly 1 cycle, data_o = 0xA5, 991 cycles after the start edge; no error pulses.
- Send 0x3C then 0xC3 back-to-back with ready_i = 0 → data_o = 0x3C held with valid_o high; overrun_o pulses once at the second stop; data_o is still 0x3C.
- Send a frame with stop bit = 0 (0x55), then hold the line low for 3 bit times → exactly one frame_err_o pulse, valid_o stays 0, and the next 0x81 is received correctly.
- Pulse rx_i low for 20 cycles (glitch) → no valid_o and no errors; FSM back in IDLE; a following byte 0x00 is received correctly.
- Assert rst_n = 0 in the middle of bit 4 of 0xF0, release after 10 cycles, then send 0x12 → all outputs 0 during reset; 0x12 is received and there is no spurious byte.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 (correct) → valid_o with data_o = 0x07. Send 0x07 with parity 0 → parity_err_o pulse and no valid_o.
